// File: rtl/regfile_param.sv
// NUM_REGS x DATA_W register file: R0 reads zero, two combinational read ports, one write port
// with optional write->read bypass, plus a soft-clear sequencer and a valid/ready register dump.
module regfile_param #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy,
    output logic              wr_drop,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last
);

    typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_done_q, clr_done_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_acc;

    always_comb wr_acc = wr_en && (wr_addr != '0) && (state_q != CLEAR);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        regs_d     = regs_q;
        if (wr_acc) regs_d[wr_addr] = wr_data;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = ADDR_W'(1);
                end else if (dump_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[idx_q] = '0;
                idx_d         = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // R0 is a constant zero; synthesis folds this slot away
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
        if ((BYPASS != 0) && wr_acc && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if ((BYPASS != 0) && wr_acc && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    end

    always_comb begin
        busy       = (state_q == CLEAR);
        wr_drop    = wr_en && (wr_addr != '0) && (state_q == CLEAR);
        clr_done   = clr_done_q;
        dump_valid = (state_q == DUMP);
        dump_addr  = dump_valid ? idx_q : '0;
        dump_data  = dump_valid ? regs_q[idx_q] : '0;
        dump_last  = dump_valid && (idx_q == LAST_IDX);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios followed by random traffic, checked against
// an array-based model of the register file, clear countdown and dump beat counter.
module tb_regfile_param;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic wr_en = 1'b0, clr_req = 1'b0, dump_req = 1'b0, dump_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [DATA_W-1:0] wr_data = '0;

    logic [DATA_W-1:0] rd_data1, rd_data2, dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic clr_done, busy, wr_drop, dump_valid, dump_last;

    logic [DATA_W-1:0] rd1_nb, rd2_nb, dump_data_nb;
    logic [ADDR_W-1:0] dump_addr_nb;
    logic clr_done_nb, busy_nb, wr_drop_nb, dump_valid_nb, dump_last_nb;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [DATA_W-1:0] mregs [NUM_REGS];
    int clr_left;
    bit dumping;
    int beat;
    bit m_done;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy), .wr_drop(wr_drop),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last)
    );

    regfile_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd1_nb), .rd_addr2(rd_addr2), .rd_data2(rd2_nb),
        .clr_req(clr_req), .clr_done(clr_done_nb), .busy(busy_nb), .wr_drop(wr_drop_nb),
        .dump_req(dump_req), .dump_valid(dump_valid_nb), .dump_ready(dump_ready),
        .dump_addr(dump_addr_nb), .dump_data(dump_data_nb), .dump_last(dump_last_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs before the edge, then advance the model at the edge.
    task automatic cycle();
        bit acc;
        logic [DATA_W-1:0] e_daddr, e_ddata;
        @(negedge clk);
        acc = wr_en && (wr_addr != 0) && (clr_left == 0);
        chk("rd1", rd_data1, (acc && wr_addr == rd_addr1) ? wr_data : mregs[rd_addr1]);
        chk("rd2", rd_data2, (acc && wr_addr == rd_addr2) ? wr_data : mregs[rd_addr2]);
        chk("rd1_nobyp", rd1_nb, mregs[rd_addr1]);
        chk("rd2_nobyp", rd2_nb, mregs[rd_addr2]);
        e_daddr = dumping ? DATA_W'(beat) : '0;
        e_ddata = dumping ? mregs[beat] : '0;
        chk("busy", busy, clr_left > 0);
        chk("clr_done", clr_done, m_done);
        chk("wr_drop", wr_drop, (clr_left > 0) && wr_en && (wr_addr != 0));
        chk("dump_valid", dump_valid, dumping);
        chk("dump_addr", dump_addr, e_daddr);
        chk("dump_data", dump_data, e_ddata);
        chk("dump_last", dump_last, dumping && (beat == NUM_REGS - 1));
        chk("nb_ctrl", {busy_nb, clr_done_nb, wr_drop_nb, dump_valid_nb, dump_last_nb},
            {busy, clr_done, wr_drop, dump_valid, dump_last});
        chk("nb_dump", {dump_addr_nb, dump_data_nb}, {dump_addr, dump_data});
        @(posedge clk);
        m_done = 1'b0;
        if (acc) mregs[wr_addr] = wr_data;
        if (clr_left > 0) begin
            mregs[NUM_REGS - clr_left] = '0;
            clr_left--;
            if (clr_left == 0) m_done = 1'b1;
        end else if (dumping) begin
            if (dump_ready) begin
                if (beat == NUM_REGS - 1) dumping = 1'b0;
                else beat++;
            end
        end else if (clr_req) begin
            clr_left = NUM_REGS - 1;
        end else if (dump_req) begin
            dumping = 1'b1;
            beat = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
        clr_left = 0;
        dumping = 1'b0;
        beat = 0;
        m_done = 1'b0;
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_ctrl", {busy, clr_done, dump_last, dump_addr}, '0);
        chk("rst_rd1", rd_data1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs();
        wr_en = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_addr = ADDR_W'(i);
            wr_data = DATA_W'(i * 8'h11);
            cycle();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int n;
        int beats;
        #1;
        do_reset();

        // 1: basic write then read
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        cycle();
        wr_en = 1'b0; rd_addr1 = 3'd3; rd_addr2 = 3'd0;
        #1;
        chk("t1_rd1", rd_data1, 8'hA5);
        chk("t1_rd2", rd_data2, 8'h00);
        cycle();

        // 2: same-cycle bypass on both ports
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
        #1;
        chk("t2_byp1", rd_data1, 8'h3C);
        chk("t2_byp2", rd_data2, 8'h3C);
        chk("t2_nobyp1", rd1_nb, 8'h00);
        chk("t2_nobyp2", rd2_nb, 8'h00);
        cycle();

        // 3: writes to R0 are ignored without wr_drop
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rd_addr1 = 3'd0;
        #1;
        chk("t3_wr_drop", wr_drop, 1'b0);
        chk("t3_byp_r0", rd_data1, 8'h00);
        cycle();
        wr_en = 1'b0;
        #1;
        chk("t3_r0", rd_data1, 8'h00);
        cycle();

        // 4: soft clear with a dropped write
        load_regs();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            n++;
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h99;
                #1;
                chk("t4_wr_drop", wr_drop, 1'b1);
            end
            cycle();
            wr_en = 1'b0;
        end
        chk("t4_busy_cycles", n, 7);
        chk("t4_clr_done", clr_done, 1'b1);
        cycle();
        chk("t4_clr_done_pulse", clr_done, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr1 = ADDR_W'(i);
            #1;
            chk("t4_cleared", rd_data1, 8'h00);
            cycle();
        end

        // 5: dump with ready toggling
        load_regs();
        dump_req = 1'b1;
        cycle();
        dump_req = 1'b0;
        beats = 0;
        for (int t = 0; t < 40 && dump_valid; t++) begin
            dump_ready = t[0];
            #1;
            chk("t5_addr", dump_addr, beats);
            chk("t5_data", dump_data, beats * 8'h11);
            chk("t5_last", dump_last, beats == NUM_REGS - 1);
            if (dump_ready) beats++;
            cycle();
        end
        dump_ready = 1'b0;
        chk("t5_beats", beats, 8);
        chk("t5_idle", dump_valid, 1'b0);
        clr_req = 1'b1; dump_req = 1'b1;
        cycle();
        clr_req = 1'b0; dump_req = 1'b0;
        chk("t5_prio_busy", busy, 1'b1);
        chk("t5_prio_dump", dump_valid, 1'b0);
        for (int k = 0; k < 20 && busy; k++) cycle();
        chk("t5_clear_end", busy, 1'b0);
        cycle();

        // 6: reset in the middle of a dump
        load_regs();
        dump_req = 1'b1;
        cycle();
        dump_req = 1'b0; dump_ready = 1'b1;
        repeat (3) cycle();
        chk("t6_beat3", dump_addr, 3);
        do_reset();
        dump_ready = 1'b0; dump_req = 1'b1;
        cycle();
        dump_req = 1'b0;
        chk("t6_restart_valid", dump_valid, 1'b1);
        chk("t6_restart_addr", dump_addr, 0);
        dump_ready = 1'b1;
        for (int k = 0; k < 20 && dump_valid; k++) begin
            #1;
            chk("t6_zero_data", dump_data, 8'h00);
            cycle();
        end
        chk("t6_dump_end", dump_valid, 1'b0);

        // random traffic against the model
        for (int t = 0; t < 400; t++) begin
            wr_en      = $urandom_range(0, 1);
            wr_addr    = ADDR_W'($urandom);
            wr_data    = DATA_W'($urandom);
            rd_addr1   = ADDR_W'($urandom);
            rd_addr2   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
            clr_req    = ($urandom_range(0, 15) == 0);
            dump_req   = ($urandom_range(0, 7) == 0);
            dump_ready = $urandom_range(0, 1);
            cycle();
        end
        wr_en = 1'b0; clr_req = 1'b0; dump_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
